instr_fetch_queue: RTL and testbench

- Instruction prefetch stage directly upstream of the CPU controller.
- Issues sequential reads to the synchronous instruction memory and tracks in-flight reads, with fixed read latency MEM_LAT.
- Buffers returned words in a small queue. Hands them to the controller over a valid/ready handshake, together with each word's fetch address.
- Supports a pc redirect (jump) that discards queued and in-flight words, and a halt input that stops new issue.

---
 rtl/osecpu_pkg.sv | 19 +
 rtl/sync_fifo.sv | 68 ++++++
 rtl/instr_fetch_queue.sv | 101 ++++++++++
 tb/tb_instr_fetch_queue.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/osecpu_pkg.sv
// Shared types and defaults for the osecpu instruction path.
package osecpu_pkg;

    localparam int ADDR_W_DEF = 16;
    localparam int DATA_W_DEF = 32;

    localparam logic [7:0] OP_END = 8'hF0;

    typedef struct packed {
        logic [7:0]  op;
        logic [23:0] operand;
    } instr_t;

    typedef struct packed {
        logic [ADDR_W_DEF-1:0] pc;
        logic [DATA_W_DEF-1:0] word;
    } fetch_entry_t;

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO with a registered head entry and flush.
module sync_fifo
    import osecpu_pkg::*;
#(
    parameter  int WIDTH = ADDR_W_DEF + DATA_W_DEF,
    parameter  int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    input  logic             flush,
    output logic [WIDTH-1:0] head,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_nxt;
    logic [CNT_W-1:0] left;
    logic             pop_ok;
    logic             push_ok;

    // Accept/advance decisions and the entry count left after a pop.
    always_comb begin
        pop_ok  = pop && (count != '0);
        push_ok = push && ((count != CNT_W'(DEPTH)) || pop_ok);
        rd_nxt  = rd_ptr + PTR_W'(pop_ok);
        left    = count - CNT_W'(pop_ok);
    end

    // Storage array write on an accepted push.
    always_ff @(posedge clk) begin
        if (push_ok && !flush) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers, count and registered head; the head holds while empty.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            head   <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            rd_ptr <= rd_nxt;
            wr_ptr <= wr_ptr + PTR_W'(push_ok);
            count  <= left + CNT_W'(push_ok);
            // Next head is an already-stored entry unless the queue drains to
            // just the word being pushed this edge.
            if (left != '0) begin
                head <= mem[rd_nxt];
            end else if (push_ok) begin
                head <= push_data;
            end
        end
    end

endmodule

// File: rtl/instr_fetch_queue.sv
// Instruction prefetch: credit-limited sequential issue, in-flight tracking
// and a small queue handing words to the controller.
module instr_fetch_queue
    import osecpu_pkg::*;
#(
    parameter  int ADDR_W  = ADDR_W_DEF,
    parameter  int DATA_W  = DATA_W_DEF,
    parameter  int DEPTH   = 4,
    parameter  int MEM_LAT = 1,
    localparam int CNT_W   = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              reset,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] instr,
    output logic [ADDR_W-1:0] instr_pc,
    output logic              instr_valid,
    input  logic              instr_ready,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    input  logic              halt,
    output logic [CNT_W-1:0]  occupancy
);

    localparam int SUM_W = CNT_W + 2;
    localparam int ENT_W = ADDR_W + DATA_W;

    logic [ADDR_W-1:0] fetch_pc;
    logic [MEM_LAT-1:0] trk_vld;
    logic [ADDR_W-1:0] trk_pc [MEM_LAT];
    logic [SUM_W-1:0]  inflight;
    logic              credit_ok;
    logic              push;
    logic              pop;
    logic [ENT_W-1:0]  head;

    // Credit check: queued plus outstanding reads must stay below DEPTH.
    always_comb begin
        inflight = '0;
        for (int unsigned i = 0; i < MEM_LAT; i++) begin
            inflight = inflight + SUM_W'(trk_vld[i]);
        end
        credit_ok = (SUM_W'(occupancy) + inflight) < SUM_W'(DEPTH);
        mem_rd    = reset && !halt && !redirect && credit_ok;
        mem_addr  = fetch_pc;
        push      = trk_vld[MEM_LAT-1] && !redirect;
        pop       = instr_valid && instr_ready && !redirect;
    end

    // Fetch pointer: redirect wins, otherwise advance on each issued read.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetch_pc <= '0;
        end else if (redirect) begin
            fetch_pc <= redirect_pc;
        end else if (mem_rd) begin
            fetch_pc <= fetch_pc + 1'b1;
        end
    end

    // In-flight shift register; a redirect drops every outstanding read.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            trk_vld <= '0;
            for (int unsigned i = 0; i < MEM_LAT; i++) begin
                trk_pc[i] <= '0;
            end
        end else begin
            for (int unsigned i = 1; i < MEM_LAT; i++) begin
                trk_vld[i] <= trk_vld[i-1];
                trk_pc[i]  <= trk_pc[i-1];
            end
            trk_vld[0] <= mem_rd;
            trk_pc[0]  <= fetch_pc;
            if (redirect) begin
                trk_vld <= '0;
            end
        end
    end

    sync_fifo #(
        .WIDTH (ENT_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data ({trk_pc[MEM_LAT-1], mem_rdata}),
        .pop       (pop),
        .flush     (redirect),
        .head      (head),
        .count     (occupancy)
    );

    assign instr_valid = (occupancy != '0);
    assign instr_pc    = head[ENT_W-1:DATA_W];
    assign instr       = head[DATA_W-1:0];

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Bench for instr_fetch_queue: two instances (MEM_LAT 1 and 3) share the
// controller-side stimulus; each has its own memory responder and model.
module tb_instr_fetch_queue;
    import osecpu_pkg::*;

    localparam int AW    = 16;
    localparam int DW    = 32;
    localparam int DEPTH = 4;

    logic          clk;
    logic          reset;
    logic          instr_ready;
    logic          redirect;
    logic [AW-1:0] redirect_pc;
    logic          halt;

    logic [AW-1:0] mem_addr    [2];
    logic          mem_rd      [2];
    logic [DW-1:0] mem_rdata   [2];
    logic [DW-1:0] instr       [2];
    logic [AW-1:0] instr_pc    [2];
    logic          instr_valid [2];
    logic [2:0]    occupancy   [2];

    int n_tests;
    int n_fail;
    int cyc;
    int lat [2];

    // reference model state
    fetch_entry_t  q     [2][8];
    int            qn    [2];
    logic [AW-1:0] o_pc  [2][8];
    int            o_due [2][8];
    int            on    [2];
    logic [AW-1:0] fpc   [2];
    logic [AW-1:0] hd_pc [2];
    logic [DW-1:0] hd_wd [2];

    // memory responder state (physical reads, independent of redirects)
    logic [AW-1:0] mh_addr [2][8];
    int            mh_due  [2][8];
    int            mh_n    [2];

    instr_fetch_queue #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH), .MEM_LAT(1)) dut_l1 (
        .clk(clk), .reset(reset),
        .mem_addr(mem_addr[0]), .mem_rd(mem_rd[0]), .mem_rdata(mem_rdata[0]),
        .instr(instr[0]), .instr_pc(instr_pc[0]), .instr_valid(instr_valid[0]),
        .instr_ready(instr_ready), .redirect(redirect), .redirect_pc(redirect_pc),
        .halt(halt), .occupancy(occupancy[0])
    );

    instr_fetch_queue #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH), .MEM_LAT(3)) dut_l3 (
        .clk(clk), .reset(reset),
        .mem_addr(mem_addr[1]), .mem_rd(mem_rd[1]), .mem_rdata(mem_rdata[1]),
        .instr(instr[1]), .instr_pc(instr_pc[1]), .instr_valid(instr_valid[1]),
        .instr_ready(instr_ready), .redirect(redirect), .redirect_pc(redirect_pc),
        .halt(halt), .occupancy(occupancy[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [DW-1:0] word_of(input logic [AW-1:0] a);
        return {16'h0000, a} ^ 32'hA500_0000;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic model_reset(input int k);
        qn[k]    = 0;
        on[k]    = 0;
        fpc[k]   = '0;
        hd_pc[k] = '0;
        hd_wd[k] = '0;
    endtask

    task automatic check_all();
        for (int k = 0; k < 2; k++) begin
            logic exp_rd;
            exp_rd = reset && !halt && !redirect && ((qn[k] + on[k]) < DEPTH);
            chk($sformatf("mem_rd[L%0d]", lat[k]), 32'(mem_rd[k]), 32'(exp_rd));
            chk($sformatf("mem_addr[L%0d]", lat[k]), 32'(mem_addr[k]), 32'(fpc[k]));
            chk($sformatf("instr_valid[L%0d]", lat[k]), 32'(instr_valid[k]), 32'(qn[k] > 0));
            chk($sformatf("instr_pc[L%0d]", lat[k]), 32'(instr_pc[k]), 32'(hd_pc[k]));
            chk($sformatf("instr[L%0d]", lat[k]), instr[k], hd_wd[k]);
            chk($sformatf("occupancy[L%0d]", lat[k]), 32'(occupancy[k]), 32'(qn[k]));
            chk($sformatf("occ_bound[L%0d]", lat[k]), 32'(occupancy[k] <= DEPTH), 32'd1);
        end
    endtask

    task automatic model_edge();
        for (int k = 0; k < 2; k++) begin
            if (!reset) begin
                model_reset(k);
            end else if (redirect) begin
                qn[k]  = 0;
                on[k]  = 0;
                fpc[k] = redirect_pc;
            end else begin
                logic issue;
                issue = !halt && ((qn[k] + on[k]) < DEPTH);
                if (qn[k] > 0 && instr_ready) begin
                    for (int j = 0; j < qn[k] - 1; j++) q[k][j] = q[k][j+1];
                    qn[k]--;
                end
                if (on[k] > 0 && o_due[k][0] == cyc) begin
                    q[k][qn[k]].pc   = o_pc[k][0];
                    q[k][qn[k]].word = word_of(o_pc[k][0]);
                    qn[k]++;
                    for (int j = 0; j < on[k] - 1; j++) begin
                        o_pc[k][j]  = o_pc[k][j+1];
                        o_due[k][j] = o_due[k][j+1];
                    end
                    on[k]--;
                end
                if (issue) begin
                    o_pc[k][on[k]]  = fpc[k];
                    o_due[k][on[k]] = cyc + lat[k];
                    on[k]++;
                    fpc[k] = fpc[k] + 16'd1;
                end
            end
            if (qn[k] > 0) begin
                hd_pc[k] = q[k][0].pc;
                hd_wd[k] = q[k][0].word;
            end
        end
    endtask

    // One clock cycle: drive read data, check, record reads, advance model.
    task automatic step();
        for (int k = 0; k < 2; k++) begin
            logic [DW-1:0] d;
            d = $urandom;
            for (int j = 0; j < mh_n[k]; j++) begin
                if (mh_due[k][j] == cyc) d = word_of(mh_addr[k][j]);
            end
            mem_rdata[k] = d;
        end
        #2;
        check_all();
        for (int k = 0; k < 2; k++) begin
            if (mem_rd[k] === 1'b1 && mh_n[k] < 8) begin
                mh_addr[k][mh_n[k]] = mem_addr[k];
                mh_due[k][mh_n[k]]  = cyc + lat[k];
                mh_n[k]++;
            end
        end
        @(posedge clk);
        model_edge();
        for (int k = 0; k < 2; k++) begin
            int w;
            w = 0;
            for (int j = 0; j < mh_n[k]; j++) begin
                if (mh_due[k][j] > cyc) begin
                    mh_addr[k][w] = mh_addr[k][j];
                    mh_due[k][w]  = mh_due[k][j];
                    w++;
                end
            end
            mh_n[k] = w;
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic drive(input logic rdy, input logic hlt, input logic rd, input logic [AW-1:0] rpc);
        instr_ready = rdy;
        halt        = hlt;
        redirect    = rd;
        redirect_pc = rpc;
        step();
    endtask

    task automatic run(input int n, input logic rdy, input logic hlt);
        for (int i = 0; i < n; i++) drive(rdy, hlt, 1'b0, 16'h0000);
    endtask

    initial begin
        n_tests     = 0;
        n_fail      = 0;
        cyc         = 0;
        lat[0]      = 1;
        lat[1]      = 3;
        reset       = 1'b0;
        instr_ready = 1'b0;
        halt        = 1'b0;
        redirect    = 1'b0;
        redirect_pc = '0;
        for (int k = 0; k < 2; k++) begin
            mem_rdata[k] = '0;
            mh_n[k]      = 0;
            model_reset(k);
        end
        @(negedge clk);

        // held in reset
        run(2, 1'b1, 1'b0);

        // release: streaming with ready high
        reset = 1'b1;
        run(12, 1'b1, 1'b0);

        // back-pressure saturates the queue, then drains in order
        run(10, 1'b0, 1'b0);
        run(8, 1'b1, 1'b0);

        // redirect with words queued and a read in flight
        run(2, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b1, 16'h0100);
        run(6, 1'b1, 1'b0);

        // redirect alongside a handshake, then a second redirect
        run(3, 1'b1, 1'b0);
        drive(1'b1, 1'b0, 1'b1, 16'h0150);
        drive(1'b1, 1'b0, 1'b1, 16'h0200);
        run(8, 1'b1, 1'b0);

        // wrap of the fetch pointer across a 3-cycle halt
        drive(1'b1, 1'b0, 1'b1, 16'hFFFE);
        run(2, 1'b1, 1'b0);
        run(3, 1'b1, 1'b1);
        run(8, 1'b1, 1'b0);

        // randomized traffic
        for (int i = 0; i < 300; i++) begin
            logic [AW-1:0] rpc;
            rpc = ($urandom_range(0, 1) == 0) ? AW'($urandom)
                                              : 16'hFFFC + AW'($urandom_range(0, 3));
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 9) == 0,
                  $urandom_range(0, 29) == 0, rpc);
        end

        // asynchronous reset in the middle of a stream
        run(6, 1'b1, 1'b0);
        reset = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) model_reset(k);
        check_all();
        run(2, 1'b1, 1'b0);
        reset = 1'b1;
        run(12, 1'b1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
